// File: rtl/adder_sweep_checker.sv
// Exhaustive on-chip sweep of a WIDTH-bit adder: drives every {cin, b, a}
// vector, compares the returned {cout, sum} against a golden add, and keeps stats.
module adder_sweep_checker #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    output logic                 op_cin,
    input  logic [WIDTH-1:0]     adder_sum,
    input  logic                 adder_cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   mismatch_count,
    output logic                 fail_valid,
    output logic [2*WIDTH:0]     fail_vector,
    output logic [WIDTH:0]       fail_result
);

    localparam int IW  = 2 * WIDTH + 1;
    localparam int CW  = 2 * WIDTH + 2;
    localparam int RW  = WIDTH + 1;
    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK,
        DONE
    } state_t;

    state_t          state;
    state_t          state_d;

    logic [IW-1:0]   idx;
    logic [SCW-1:0]  settle_cnt;

    logic            sweep_start;
    logic            settle_last;
    logic            idx_last;
    logic            active;

    logic [WIDTH-1:0] cur_a;
    logic [WIDTH-1:0] cur_b;
    logic             cur_cin;
    logic [RW-1:0]    expected;
    logic [RW-1:0]    observed;
    logic             mismatch;

    // Decode the current vector index into the three adder operands
    always_comb begin
        cur_a   = idx[WIDTH-1:0];
        cur_b   = idx[2*WIDTH-1:WIDTH];
        cur_cin = idx[2*WIDTH];
    end

    // Golden model and comparison against the adder's sampled result
    always_comb begin
        expected = {1'b0, cur_a}
                 + {1'b0, cur_b}
                 + {{WIDTH{1'b0}}, cur_cin};
        observed = {adder_cout, adder_sum};
        mismatch = (state == CHECK) && (observed != expected);
    end

    // Qualifiers shared by the FSM and the datapath
    always_comb begin
        sweep_start = ((state == IDLE) || (state == DONE)) && start;
        settle_last = (settle_cnt == SCW'(SETTLE - 1));
        idx_last    = &idx;
        active      = (state == DRIVE) || (state == CHECK);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic: DRIVE holds SETTLE cycles, CHECK takes one
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (start) state_d = DRIVE;
            end
            DRIVE: begin
                if (settle_last) state_d = CHECK;
            end
            CHECK: begin
                if (idx_last) state_d = DONE;
                else          state_d = DRIVE;
            end
            DONE: begin
                if (start) state_d = DRIVE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Vector index: cleared on a new sweep, advanced after each CHECK
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (sweep_start) begin
            idx <= '0;
        end else if ((state == CHECK) && !idx_last) begin
            idx <= idx + IW'(1);
        end
    end

    // Settle counter: counts cycles spent in DRIVE for the current vector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
        end else if (sweep_start) begin
            settle_cnt <= '0;
        end else if (state == DRIVE) begin
            if (settle_last) settle_cnt <= '0;
            else             settle_cnt <= settle_cnt + SCW'(1);
        end
    end

    // Mismatch counter: wide enough for every vector to fail without wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_count <= '0;
        end else if (sweep_start) begin
            mismatch_count <= '0;
        end else if (mismatch) begin
            mismatch_count <= mismatch_count + CW'(1);
        end
    end

    // First-failure capture: only the earliest failing vector is kept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_valid  <= 1'b0;
            fail_vector <= '0;
            fail_result <= '0;
        end else if (sweep_start) begin
            fail_valid  <= 1'b0;
            fail_vector <= '0;
            fail_result <= '0;
        end else if (mismatch && !fail_valid) begin
            fail_valid  <= 1'b1;
            fail_vector <= idx;
            fail_result <= observed;
        end
    end

    // Operands are only driven while a sweep is running, otherwise zero
    always_comb begin
        op_a   = active ? cur_a   : '0;
        op_b   = active ? cur_b   : '0;
        op_cin = active ? cur_cin : 1'b0;
    end

    // Status outputs derived from state and statistics
    always_comb begin
        busy = active;
        done = (state == DONE);
        pass = (state == DONE) && (mismatch_count == '0);
    end

endmodule

// File: tb/tb_adder_sweep_checker.sv
// Directed bench for adder_sweep_checker: correct, stuck-at and Trojan
// adders, ignored start pulses, async reset mid-sweep, and SETTLE=3.
module tb_adder_sweep_checker;

    logic       clk;
    logic       rst;
    logic       start;
    logic       start3;
    int         mode;
    int         checks;
    int         errors;
    int         cyc;

    logic [3:0] op_a, op_b;
    logic       op_cin;
    logic [3:0] s_sum;
    logic       s_cout;
    logic       busy, done, pass;
    logic [9:0] mismatch_count;
    logic       fail_valid;
    logic [8:0] fail_vector;
    logic [4:0] fail_result;

    logic [3:0] op_a3, op_b3;
    logic       op_cin3;
    logic [3:0] s_sum3;
    logic       s_cout3;
    logic       busy3, done3, pass3;
    logic [9:0] mismatch_count3;
    logic       fail_valid3;
    logic [8:0] fail_vector3;
    logic [4:0] fail_result3;

    adder_sweep_checker u_dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .op_a           (op_a),
        .op_b           (op_b),
        .op_cin         (op_cin),
        .adder_sum      (s_sum),
        .adder_cout     (s_cout),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .mismatch_count (mismatch_count),
        .fail_valid     (fail_valid),
        .fail_vector    (fail_vector),
        .fail_result    (fail_result)
    );

    adder_sweep_checker #(.WIDTH(4), .SETTLE(3)) u_dut3 (
        .clk            (clk),
        .rst            (rst),
        .start          (start3),
        .op_a           (op_a3),
        .op_b           (op_b3),
        .op_cin         (op_cin3),
        .adder_sum      (s_sum3),
        .adder_cout     (s_cout3),
        .busy           (busy3),
        .done           (done3),
        .pass           (pass3),
        .mismatch_count (mismatch_count3),
        .fail_valid     (fail_valid3),
        .fail_vector    (fail_vector3),
        .fail_result    (fail_result3)
    );

    // Adder under test with selectable fault: 1 = sum[0] stuck-at-0,
    // 2 = carry_out inverted only for a=F, b=F, cin=1
    always_comb begin
        {s_cout, s_sum} = {1'b0, op_a} + {1'b0, op_b} + {4'b0, op_cin};
        if (mode == 1) s_sum[0] = 1'b0;
        if (mode == 2 && op_a == 4'hF && op_b == 4'hF && op_cin)
            s_cout = ~s_cout;
    end

    // Always-correct adder for the SETTLE=3 instance
    always_comb begin
        {s_cout3, s_sum3} = {1'b0, op_a3} + {1'b0, op_b3} + {4'b0, op_cin3};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start a sweep on the default instance and run until done; start is
    // re-asserted while busy at cycles p1 and p2
    task automatic run_sweep(input int p1, input int p2, output int n);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("done_cleared", done, 0);
        check("mm_cleared", mismatch_count, 0);
        check("fv_cleared", fail_valid, 0);
        check("op_a_vec0", op_a, 0);
        n = 0;
        while (n < 3000) begin
            n++;
            start = (n == p1 || n == p2);
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) break;
        end
        check("sweep_done_in_budget", done, 1);
    endtask

    // SETTLE=3 sweep with operand hold checks at vector boundaries
    task automatic run_sweep3(output int n);
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        check("s3_busy_after_start", busy3, 1);
        check("s3_done_cleared", done3, 0);
        n = 0;
        while (n < 5000) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 3)    check("s3_a_c3", op_a3, 0);
            if (n == 4)    check("s3_a_c4", op_a3, 1);
            if (n == 7)    check("s3_a_c7", op_a3, 1);
            if (n == 8)    check("s3_a_c8", op_a3, 2);
            if (n == 63)   check("s3_b_c63", op_b3, 0);
            if (n == 64)   check("s3_b_c64", op_b3, 1);
            if (n == 1023) check("s3_cin_c1023", op_cin3, 0);
            if (n == 1024) check("s3_cin_c1024", op_cin3, 1);
            if (done3) break;
        end
        check("s3_done_in_budget", done3, 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mode   = 0;
        rst    = 1'b1;
        start  = 1'b0;
        start3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_mm", mismatch_count, 0);
        check("rst_op", {op_cin, op_b, op_a}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Correct adder
        run_sweep(-1, -1, cyc);
        check("ok_cycles", cyc, 1024);
        check("ok_pass", pass, 1);
        check("ok_mm", mismatch_count, 0);
        check("ok_fv", fail_valid, 0);
        check("ok_busy", busy, 0);
        check("ok_op_zero", {op_cin, op_b, op_a}, 0);

        // sum[0] stuck-at-0, started from DONE
        mode = 1;
        run_sweep(-1, -1, cyc);
        check("sa0_cycles", cyc, 1024);
        check("sa0_mm", mismatch_count, 256);
        check("sa0_fv", fail_valid, 1);
        check("sa0_vec", fail_vector, 9'h001);
        check("sa0_res", fail_result, 5'h00);
        check("sa0_pass", pass, 0);

        // Single-vector Trojan on carry_out
        mode = 2;
        run_sweep(-1, -1, cyc);
        check("troj_mm", mismatch_count, 1);
        check("troj_vec", fail_vector, 9'h1FF);
        check("troj_res", fail_result, 5'h0F);
        check("troj_pass", pass, 0);

        // Same Trojan with start pulses while busy
        run_sweep(10, 500, cyc);
        check("poke_cycles", cyc, 1024);
        check("poke_mm", mismatch_count, 1);
        check("poke_vec", fail_vector, 9'h1FF);
        check("poke_res", fail_result, 5'h0F);

        // Async reset at cycle 300 of a faulty sweep
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("pre_rst_busy", busy, 1);
        check("pre_rst_mm", mismatch_count, 75);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_mm", mismatch_count, 0);
        check("arst_fv", fail_valid, 0);
        check("arst_vec", fail_vector, 0);
        check("arst_res", fail_result, 0);
        check("arst_op", {op_cin, op_b, op_a}, 0);
        @(negedge clk);
        rst = 1'b0;
        mode = 0;
        run_sweep(-1, -1, cyc);
        check("post_rst_cycles", cyc, 1024);
        check("post_rst_pass", pass, 1);

        // SETTLE=3 instance, twice
        run_sweep3(cyc);
        check("s3_cycles", cyc, 2048);
        check("s3_pass", pass3, 1);
        run_sweep3(cyc);
        check("s3_rerun_cycles", cyc, 2048);
        check("s3_rerun_pass", pass3, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_sweep_checker.md
Name: adder_sweep_checker

Overview:
- Sequential stimulus-and-check stage wrapped around the 4-bit adder (ports a, b, carry_in, sum, carry_out).
- On start it drives every operand combination into the adder and samples the adder's result. It compares each result against an internal golden a+b+cin and records the mismatch count and the first failing vector.
- It is the on-chip replacement for the exhaustive simulation sweep. Its main use is Trojan and fault detection on the adder under test.

Parameters:
- WIDTH, 4, operand width of the adder under test (a, b, sum).
- SETTLE, 1, cycles each vector is held before the result is sampled. Minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep. Sampled only in IDLE or DONE.
- op_a  out  WIDTH  operand a driven to the adder.
- op_b  out  WIDTH  operand b driven to the adder.
- op_cin  out  1  carry_in driven to the adder.
- adder_sum  in  WIDTH  sum returned by the adder.
- adder_cout  in  1  carry_out returned by the adder.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete. Held until the next start or reset.
- pass  out  1  done and mismatch_count == 0.
- mismatch_count  out  2*WIDTH+2  number of failing vectors.
- fail_valid  out  1  at least one mismatch has been captured.
- fail_vector  out  2*WIDTH+1  {cin, b, a} of the first failing vector.
- fail_result  out  WIDTH+1  {cout, sum} observed for the first failing vector.

Behaviour:
- Reset value: all outputs 0, state IDLE, vector index 0, settle counter 0. Reset is asynchronous and applies at any time, including mid-sweep. After reset the next start begins again at vector 0.
- Vector index idx has 2*WIDTH+1 bits, 512 vectors at the default width. Mapping: op_a = idx[WIDTH-1:0], op_b = idx[2W-1:W], op_cin = idx[2W].
  - Order: a varies fastest, then b, then cin.
- State IDLE:
  - Operands are 0 and busy=0.
  - start=1 moves to DRIVE. idx, settle counter, mismatch_count, fail_valid, fail_vector and fail_result are all cleared.
- State DRIVE:
  - busy=1 and the operands show the current idx.
  - The block stays in DRIVE for exactly SETTLE cycles, then moves to CHECK.
- State CHECK (1 cycle):
  - The operands still show idx.
  - expected = zero-extended a + b + cin, WIDTH+1 bits.
  - If {adder_cout, adder_sum} != expected:
    - mismatch_count increments.
    - If fail_valid=0, the block captures fail_vector=idx and fail_result={adder_cout, adder_sum}, then sets fail_valid=1.
  - If idx is all-ones, move to DONE. Otherwise idx increments and the block returns to DRIVE.
- State DONE:
  - busy=0, done=1, operands return to 0, and the statistics hold.
  - pass = (mismatch_count == 0).
  - start=1 clears done and the statistics and goes to DRIVE, the same as from IDLE.
- Latency: the start edge is cycle 0. done rises after 2^(2W+1)*(SETTLE+1) cycles, which is 1024 at the defaults.
- mismatch_count width covers the full 2^(2W+1) range, so it never wraps or saturates.
- start while busy=1 is ignored and has no effect on idx or statistics.
- Adder inputs are treated as purely combinational. Only the CHECK-cycle sample counts; values during DRIVE are ignored.

Test Plan:
- Correct adder model, defaults, start pulse -> busy for 1024 cycles. Then done=1, pass=1, mismatch_count=0, fail_valid=0. Operands return to 0.
- sum[0] stuck-at-0 -> mismatch_count=256. fail_vector=9'h001 ({cin=0, b=0, a=1}), fail_result=5'h00. pass=0.
- Trojan that inverts carry_out only when a=F, b=F, cin=1 -> mismatch_count=1, fail_vector=9'h1FF, fail_result=5'h0F.
- Extra start pulses at cycles 10 and 500 of a sweep -> no effect. done still at cycle 1024 with identical statistics.
- rst asserted mid-sweep at cycle 300 -> all outputs 0 immediately, without waiting for a clock edge. A new start sweeps from vector 0 and finishes 1024 cycles later.
- SETTLE=3, correct adder -> done at cycle 2048. op_a, op_b and op_cin each hold for 4 cycles. A second start from DONE clears done and repeats the sweep.
